// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C burst transactor.
//   - Command encodings driven on o_cmd towards the I2C master.
//   - Error codes reported on o_err_code.
//   - Controller state enumeration.
package i2c_pkg;

  // Command encodings understood by i2c_master_interface.
  localparam logic [2:0] CMD_IDLE      = 3'd0;
  localparam logic [2:0] CMD_START     = 3'd1;  // (repeated) START + address byte in tx_data
  localparam logic [2:0] CMD_WRITE     = 3'd2;  // write tx_data, sample slave ACK
  localparam logic [2:0] CMD_READ      = 3'd3;  // master-side raw read; not issued by this controller
  localparam logic [2:0] CMD_READ_ACK  = 3'd4;  // read a byte, master ACKs (more to follow)
  localparam logic [2:0] CMD_READ_NACK = 3'd5;  // read a byte, master NACKs (final byte)
  localparam logic [2:0] CMD_STOP      = 3'd6;

  // Completion codes.
  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_ADDR_NACK = 2'd1;
  localparam logic [1:0] ERR_DATA_NACK = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;  // also used for an illegal length

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_WR_REG,
    S_RESTART,
    S_RD_BYTE,
    S_WR_WAIT,
    S_WR_BYTE,
    S_STOP,
    S_DONE
  } state_e;

endpackage

// File: rtl/i2c_cmd_watchdog.sv
// Per-command watchdog for the I2C burst transactor.
// Only instantiated when I2C_BURST_TIMEOUT_EN is defined.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : a command was issued this cycle; begin counting
//   i_clear      : the command finished (or the expiry was acted on); stop and clear
//   o_expire     : the outstanding command has been waiting TIMEOUT_CYCLES cycles
module i2c_cmd_watchdog #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             r_run;
  logic [CNT_W-1:0] r_cnt;

  assign o_expire = r_run && (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
    end else if (r_run && !o_expire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_burst_transactor.sv
// I2C register burst transactor: multi-byte register reads/writes to one
// 7-bit device, retrying on address/register NACK. Drives the command
// handshake of i2c_master_interface (one outstanding command at a time).
// Optional feature macro: I2C_BURST_TIMEOUT_EN (per-command watchdog).
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start/i_rw/i_reg_addr/i_len   request (sampled only when idle)
//   i_wr_data/i_wr_valid/o_wr_ready write byte stream
//   o_rd_data/o_rd_valid/o_rd_last  read byte stream
//   o_busy/o_done/o_error/o_err_code transaction status
//   o_cmd/o_cmd_valid/o_tx_data      command to the I2C master
//   i_cmd_done/i_cmd_error/i_rx_data command completion from the master
module i2c_burst_transactor
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h28,
  parameter int         MAX_LEN        = 8,
  parameter int         RETRIES        = 3,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         LEN_W          = $clog2(MAX_LEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_rw,
  input  logic [7:0]       i_reg_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_wr_data,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_valid,
  output logic             o_rd_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [1:0]       o_err_code,
  output logic [2:0]       o_cmd,
  output logic             o_cmd_valid,
  output logic [7:0]       o_tx_data,
  input  logic             i_cmd_done,
  input  logic             i_cmd_error,
  input  logic [7:0]       i_rx_data
);

  localparam int RTY_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  state_e           r_state, w_state_nxt;
  logic             r_pending;     // a command has been issued and not yet completed
  logic [RTY_W-1:0] r_retry;
  logic             r_again;       // the STOP in progress ends a failed attempt; start over
  logic [LEN_W-1:0] r_cnt;         // bytes completed in this attempt
  logic [1:0]       r_err_code;
  logic             r_rd_valid, r_rd_last;
  logic [7:0]       r_rd_data;
  logic             r_rw;
  logic [7:0]       r_reg_addr;
  logic [LEN_W-1:0] r_len;
  logic [7:0]       r_wr_byte;

  logic       w_ack, w_last, w_len_bad, w_expire;
  logic       w_capture, w_cnt_inc, w_restart, w_retry_dec, w_again_set;
  logic       w_err_set, w_wr_latch, w_rd_take, w_addr_nack;
  logic [1:0] w_err_val;

  assign w_ack      = r_pending && i_cmd_done;
  assign w_last     = (r_cnt == r_len - LEN_W'(1));
  assign w_len_bad  = (i_len == '0) || (int'(i_len) > MAX_LEN);
  assign o_err_code = r_err_code;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_last  = r_rd_last;
  assign o_rd_data  = r_rd_data;

`ifdef I2C_BURST_TIMEOUT_EN
  i2c_cmd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (o_cmd_valid),
    .i_clear (w_ack || w_expire),
    .o_expire(w_expire)
  );
`else
  // No watchdog in this build: a command waits for i_cmd_done forever.
  // The comparison is constant-false and only keeps the parameter referenced.
  assign w_expire = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_cmd       = CMD_IDLE;
    o_cmd_valid = 1'b0;
    o_tx_data   = 8'h00;
    o_wr_ready  = 1'b0;
    o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    o_done      = 1'b0;
    o_error     = 1'b0;
    w_capture   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_restart   = 1'b0;
    w_retry_dec = 1'b0;
    w_again_set = 1'b0;
    w_err_set   = 1'b0;
    w_err_val   = ERR_NONE;
    w_wr_latch  = 1'b0;
    w_rd_take   = 1'b0;
    w_addr_nack = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_capture = 1'b1;
          if (w_len_bad) begin
            w_err_set   = 1'b1;
            w_err_val   = ERR_TIMEOUT;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_START;
          end
        end
      end
      S_START: begin
        o_cmd       = CMD_START;
        o_tx_data   = {DEV_ADDR, 1'b0};
        o_cmd_valid = !r_pending;
        if (w_ack && i_cmd_error) w_addr_nack = 1'b1;
        else if (w_ack)           w_state_nxt = S_WR_REG;
      end
      S_WR_REG: begin
        o_cmd       = CMD_WRITE;
        o_tx_data   = r_reg_addr;
        o_cmd_valid = !r_pending;
        if (w_ack && i_cmd_error) w_addr_nack = 1'b1;
        else if (w_ack)           w_state_nxt = r_rw ? S_RESTART : S_WR_WAIT;
      end
      S_RESTART: begin
        o_cmd       = CMD_START;
        o_tx_data   = {DEV_ADDR, 1'b1};
        o_cmd_valid = !r_pending;
        if (w_ack && i_cmd_error) w_addr_nack = 1'b1;
        else if (w_ack)           w_state_nxt = S_RD_BYTE;
      end
      S_RD_BYTE: begin
        // The master NACKs only the final byte so the slave releases SDA.
        o_cmd       = w_last ? CMD_READ_NACK : CMD_READ_ACK;
        o_cmd_valid = !r_pending;
        if (w_ack) begin
          w_rd_take = 1'b1;
          w_cnt_inc = 1'b1;
          if (w_last) w_state_nxt = S_STOP;
        end
      end
      S_WR_WAIT: begin
        o_wr_ready = 1'b1;
        if (i_wr_valid) begin
          w_wr_latch  = 1'b1;
          w_state_nxt = S_WR_BYTE;
        end
      end
      S_WR_BYTE: begin
        o_cmd       = CMD_WRITE;
        o_tx_data   = r_wr_byte;
        o_cmd_valid = !r_pending;
        if (w_ack && i_cmd_error) begin
          // Upstream bytes are already consumed, so a data NACK is final.
          w_err_set   = 1'b1;
          w_err_val   = ERR_DATA_NACK;
          w_state_nxt = S_STOP;
        end else if (w_ack) begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = w_last ? S_STOP : S_WR_WAIT;
        end
      end
      S_STOP: begin
        o_cmd       = CMD_STOP;
        o_cmd_valid = !r_pending;
        if (w_ack) begin
          if (r_again) begin
            w_restart   = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        o_error     = (r_err_code != ERR_NONE);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Address or register NACK: release the bus, then retry or give up.
    if (w_addr_nack) begin
      w_state_nxt = S_STOP;
      if (r_retry != '0) begin
        w_retry_dec = 1'b1;
        w_again_set = 1'b1;
      end else begin
        w_err_set = 1'b1;
        w_err_val = ERR_ADDR_NACK;
      end
    end

    // A hung master gets no STOP; finish straight away.
    if (r_pending && w_expire) begin
      w_state_nxt = S_DONE;
      w_err_set   = 1'b1;
      w_err_val   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending  <= 1'b0;
      r_retry    <= '0;
      r_again    <= 1'b0;
      r_cnt      <= '0;
      r_err_code <= ERR_NONE;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= 8'h00;
    end else begin
      r_rd_valid <= w_rd_take;
      r_rd_last  <= w_rd_take && w_last;
      if (w_rd_take) r_rd_data <= i_rx_data;

      if (w_ack || (r_pending && w_expire)) r_pending <= 1'b0;
      else if (o_cmd_valid)                 r_pending <= 1'b1;

      if (w_capture) begin
        r_retry    <= RTY_W'(RETRIES);
        r_again    <= 1'b0;
        r_cnt      <= '0;
        r_err_code <= ERR_NONE;
      end
      if (w_retry_dec) r_retry <= r_retry - RTY_W'(1);
      if (w_again_set) r_again <= 1'b1;
      if (w_restart) begin
        r_again <= 1'b0;
        r_cnt   <= '0;
      end
      if (w_cnt_inc) r_cnt <= r_cnt + LEN_W'(1);
      if (w_err_set) r_err_code <= w_err_val;
    end
  end

  // Request fields and the write holding byte carry no control meaning
  // until a transaction has captured them.
  always_ff @(posedge i_clk) begin
    if (w_capture) begin
      r_rw       <= i_rw;
      r_reg_addr <= i_reg_addr;
      r_len      <= i_len;
    end
    if (w_wr_latch) r_wr_byte <= i_wr_data;
  end

endmodule
